pipe_track_unit: RTL and testbench
==================================

Name: pipe_track_unit

Overview:
- Parametrised pipeline backbone that generalises the hard-wired E/M/W register chain and the external forwarding/stall logic of the current core.
- Carries a payload plus hazard metadata (rd, regwrite, is_load, source regs) through DEPTH stages. Stage 0 is Execute and stage DEPTH-1 is Write-Back.
- Per-stage valid bits, per-stage flush, back-pressure at retire, load-use stall generation, N-source forwarding selects, and retire/stall performance counters.
- Sits between decode and the regfile write port; the datapath muxes use its fwd_sel outputs.

Parameters:
- DEPTH, 3, number of tracked stages (>=2); stage 0 = Execute.
- PAYLOAD_W, 32, opaque payload bits per stage.
- REG_ADDR_W, 5, register address width.
- NSRC, 2, source operands per instruction.
- SEL_W, $clog2(DEPTH), width of each forward select.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage 0 accepts this cycle
- in_payload  in  PAYLOAD_W  payload
- in_rd  in  REG_ADDR_W  destination register
- in_regwrite  in  1  writes rd
- in_is_load  in  1  result available only at stage 2 or later
- in_src  in  NSRC*REG_ADDR_W  source registers, src j at [j*REG_ADDR_W +: REG_ADDR_W]
- flush_mask  in  DEPTH  bit i kills stage i at the next edge
- out_ready  in  1  write-back sink accepts
- out_valid  out  1  stage DEPTH-1 valid
- out_payload  out  PAYLOAD_W  stage DEPTH-1 payload
- out_rd  out  REG_ADDR_W  stage DEPTH-1 rd
- out_regwrite  out  1  valid AND regwrite of stage DEPTH-1
- stage_valid  out  DEPTH  valid bit per stage
- fwd_sel  out  NSRC*SEL_W  per source of stage 0: 0 = no forward, k = forward from stage k
- load_use_stall  out  1  load-use hazard detected this cycle
- retire_count  out  32  instructions retired (wraps)
- stall_count  out  32  cycles with load_use_stall=1 (saturates at 0xFFFF_FFFF)

Behaviour:
- Reset (reset=0 at an edge): all valid bits 0, counters 0.
- Outputs while held in reset: out_valid=0, out_regwrite=0, in_ready=1, fwd_sel=0, load_use_stall=0.
- Payload/rd registers are not reset.
- Advance chain (combinational):
  - adv[DEPTH-1] = out_ready.
  - adv[i] = !valid[i+1] | adv[i+1].
  - Stage i+1 loads stage i when adv[i]. Stage i clears valid when it advances and is not refilled.
- Retire: occurs when out_valid & out_ready; retire_count increments.
- Latency: an instruction accepted at edge T (stage 0) is at stage DEPTH-1 after edge T+DEPTH-1 with no stalls. Full throughput is 1/cycle.
- Load-use hazard: in_valid & valid[0] & is_load[0] & regwrite[0] & rd[0]!=0 & rd[0]==any in_src[j].
  - On a hazard, load_use_stall=1 and in_ready=0.
  - If stage 0 advances, it becomes a bubble (valid=0).
- in_ready = adv_into_0 & !load_use_stall, where adv_into_0 = !valid[0] | adv[0].
- Flush:
  - flush_mask[i]=1 forces valid[i]=0 after the edge, overriding any load into stage i.
  - The flushed slot's contents still count as not advanced. Upstream may still shift into stage i+1 per adv.
  - flush_mask[0] also drops an instruction accepted that same cycle; in_ready is unchanged.
- Forwarding, for each src j of stage 0:
  - Pick the smallest k in 1..DEPTH-1 with valid[k] & regwrite[k] & rd[k]!=0 & rd[k]==src0[j]. Youngest wins.
  - If k==1 and is_load[1], report 0 for k=1 and continue the search at k>=2. The load value is not ready.
  - fwd_sel = 0 if no match, or if stage 0 is invalid.
- x0 never matches, never stalls, never forwards.
- Simultaneous flush_mask[0] and a hazard: stall still reported. stall_count counts the cycle.
- retire_count wraps 0xFFFF_FFFF -> 0.

Test Plan:
- Reset, then 4 back-to-back ALU instrs (rd=1..4, DEPTH=3) with out_ready=1 -> out_rd=1 at cycle 3 after first accept; then 2, 3, 4 on consecutive cycles; retire_count=4.
- Forwarding:
  - Stream: add x5 (rd=5), then add x6 with src0=5, src1=5 -> fwd_sel={1,1} while consumer in stage 0.
  - With one bubble between producer and consumer -> fwd_sel={2,2}.
  - Producer rd=0 -> fwd_sel={0,0}.
- Load-use: load rd=7 in stage 0, in_src0=7 -> load_use_stall=1, in_ready=0 one cycle, bubble in stage 0, stall_count=1. The next cycle the consumer enters with fwd_sel src0=2.
- Back-pressure: out_ready=0 for 5 cycles with 3 valid stages -> pipe holds all payloads unchanged, in_ready=0 after the pipe fills, no retire. Releasing out_ready retires in order.
- Flush: flush_mask=3'b011 with all stages valid -> next cycle stage_valid=3'b100 (DEPTH=3) before new accepts. An instruction accepted that cycle is dropped.
- Mid-operation reset: assert reset=0 for 1 cycle with a full pipe -> stage_valid=0, counters 0, in_ready=1 on the following cycle.

Source files
------------

// File: rtl/pipe_track_unit.sv
// Hazard-tracking pipeline backbone: valid/flush/backpressure per stage, load-use stall, forward selects, counters.
// Latency DEPTH-1 edges from accept to out_valid; out_ready=0 holds the chain and in_ready falls once stage 0 cannot move.
module pipe_track_unit #(
    parameter int DEPTH      = 3,
    parameter int PAYLOAD_W  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NSRC       = 2,
    parameter int SEL_W      = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    input  logic [REG_ADDR_W-1:0]        in_rd,
    input  logic                         in_regwrite,
    input  logic                         in_is_load,
    input  logic [NSRC*REG_ADDR_W-1:0]   in_src,
    input  logic [DEPTH-1:0]             flush_mask,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [PAYLOAD_W-1:0]         out_payload,
    output logic [REG_ADDR_W-1:0]        out_rd,
    output logic                         out_regwrite,
    output logic [DEPTH-1:0]             stage_valid,
    output logic [NSRC*SEL_W-1:0]        fwd_sel,
    output logic                         load_use_stall,
    output logic [31:0]                  retire_count,
    output logic [31:0]                  stall_count
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [PAYLOAD_W-1:0]        payload_q [DEPTH];
    logic [REG_ADDR_W-1:0]       rd_q [DEPTH];
    logic [DEPTH-1:0]            regwrite_q;
    logic [1:0]                  is_load_q;
    logic [NSRC*REG_ADDR_W-1:0]  src_q;
    logic [31:0]                 retire_cnt_q, retire_cnt_d;
    logic [31:0]                 stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:0]            adv;
    logic                        adv_into_0;
    logic                        hazard;
    logic                        src_hit;
    logic                        accept;
    logic                        retire;
    logic [SEL_W-1:0]            sel;

    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = ~valid_q[i+1] | adv[i+1];
        end
    end

    always_comb begin
        src_hit = 1'b0;
        for (int j = 0; j < NSRC; j++) begin
            if (in_src[j*REG_ADDR_W +: REG_ADDR_W] == rd_q[0]) src_hit = 1'b1;
        end
        hazard = in_valid & valid_q[0] & is_load_q[0] & regwrite_q[0]
               & (rd_q[0] != '0) & src_hit;
    end

    assign adv_into_0 = ~valid_q[0] | adv[0];
    assign accept     = in_valid & adv_into_0 & ~hazard;
    assign retire     = valid_q[DEPTH-1] & out_ready;

    // Flush is applied last so it overrides both holds and loads.
    always_comb begin
        valid_d    = valid_q;
        valid_d[0] = adv_into_0 ? accept : valid_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = adv[i-1] ? valid_q[i-1] : valid_q[i];
        end
        valid_d = valid_d & ~flush_mask;
    end

    always_comb begin
        retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (hazard && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q      <= '0;
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            retire_cnt_q <= retire_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            payload_q[0]  <= in_payload;
            rd_q[0]       <= in_rd;
            regwrite_q[0] <= in_regwrite;
            is_load_q[0]  <= in_is_load;
            src_q         <= in_src;
        end
        if (adv[0]) is_load_q[1] <= is_load_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
                payload_q[i]  <= payload_q[i-1];
                rd_q[i]       <= rd_q[i-1];
                regwrite_q[i] <= regwrite_q[i-1];
            end
        end
    end

    // Scan oldest to youngest so the youngest eligible producer wins; a load in stage 1 is not ready yet.
    always_comb begin
        fwd_sel = '0;
        sel     = '0;
        for (int j = 0; j < NSRC; j++) begin
            sel = '0;
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (valid_q[k] && regwrite_q[k] && rd_q[k] != '0
                    && rd_q[k] == src_q[j*REG_ADDR_W +: REG_ADDR_W]
                    && !(k == 1 && is_load_q[1]))
                    sel = SEL_W'(k);
            end
            if (reset && valid_q[0]) fwd_sel[j*SEL_W +: SEL_W] = sel;
        end
    end

    assign in_ready       = ~reset | (adv_into_0 & ~hazard);
    assign load_use_stall = reset & hazard;
    assign out_valid      = reset & valid_q[DEPTH-1];
    assign out_regwrite   = out_valid & regwrite_q[DEPTH-1];
    assign out_payload    = payload_q[DEPTH-1];
    assign out_rd         = rd_q[DEPTH-1];
    assign stage_valid    = valid_q;
    assign retire_count   = retire_cnt_q;
    assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_track_unit.sv
// Bench for pipe_track_unit: hand-derived vector table, directed corner sequences, random traffic vs a slot model.
module tb_pipe_track_unit;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_regwrite, in_is_load, out_ready;
    logic [31:0] in_payload, out_payload, retire_count, stall_count;
    logic [4:0]  in_rd, out_rd;
    logic [9:0]  in_src;
    logic [2:0]  flush_mask, stage_valid;
    logic        out_valid, out_regwrite, load_use_stall;
    logic [3:0]  fwd_sel;

    always #5 clk = ~clk;

    pipe_track_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_payload(in_payload), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .in_is_load(in_is_load), .in_src(in_src), .flush_mask(flush_mask),
        .out_ready(out_ready), .out_valid(out_valid), .out_payload(out_payload),
        .out_rd(out_rd), .out_regwrite(out_regwrite), .stage_valid(stage_valid),
        .fwd_sel(fwd_sel), .load_use_stall(load_use_stall),
        .retire_count(retire_count), .stall_count(stall_count)
    );

    typedef struct {
        bit rst; bit iv; logic [4:0] rd; bit rw; bit ld; logic [4:0] s0; logic [4:0] s1;
        bit e_ir; bit e_ov; logic [4:0] e_ord; logic [3:0] e_fwd; bit e_st; logic [2:0] e_sv;
    } vec_t;

    typedef struct {
        bit v; logic [31:0] pl; logic [4:0] rd; bit rw; bit ld; logic [4:0] s0; logic [4:0] s1;
    } slot_t;

    slot_t       m [D];
    int unsigned m_ret = 0, m_stl = 0;
    int          tests = 0, fails = 0;
    vec_t        tbl [27];
    vec_t        nullv;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit model_hz();
        return in_valid && m[0].v && m[0].ld && m[0].rw && m[0].rd != 5'd0
            && (m[0].rd == in_src[4:0] || m[0].rd == in_src[9:5]);
    endfunction

    // Stage 0 can move when it is empty, the sink takes, or any later slot has a hole.
    task automatic model_check();
        bit hz, can0, e_ir, e_ov, e_orw, e_st, found;
        logic [1:0] sel [2];
        logic [4:0] src;
        hz   = model_hz();
        can0 = !m[0].v || out_ready;
        for (int k = 1; k < D; k++) if (!m[k].v) can0 = 1'b1;
        e_ir  = !reset ? 1'b1 : (can0 && !hz);
        e_ov  = reset && m[D-1].v;
        e_orw = e_ov && m[D-1].rw;
        e_st  = reset && hz;
        for (int j = 0; j < 2; j++) begin
            sel[j] = 2'd0;
            found  = 1'b0;
            src    = (j == 0) ? m[0].s0 : m[0].s1;
            if (reset && m[0].v) begin
                for (int k = 1; k < D; k++) begin
                    if (!found && m[k].v && m[k].rw && m[k].rd != 5'd0 && m[k].rd == src
                        && !(k == 1 && m[1].ld)) begin
                        sel[j] = 2'(k);
                        found  = 1'b1;
                    end
                end
            end
        end
        chk("model_ctl", {in_ready, out_valid, out_regwrite, load_use_stall, stage_valid, fwd_sel},
            {e_ir, e_ov, e_orw, e_st, m[2].v, m[1].v, m[0].v, sel[1], sel[0]});
        chk("model_retire_count", retire_count, m_ret);
        chk("model_stall_count", stall_count, m_stl);
        if (e_ov) chk("model_out_data", {out_payload, out_rd}, {m[D-1].pl, m[D-1].rd});
    endtask

    task automatic model_step();
        bit hz;
        hz = model_hz();
        if (!reset) begin
            for (int i = 0; i < D; i++) m[i].v = 1'b0;
            m_ret = 0;
            m_stl = 0;
        end else begin
            if (m[D-1].v && out_ready) begin
                m[D-1].v = 1'b0;
                m_ret++;
            end
            if (hz && m_stl != 32'hFFFF_FFFF) m_stl++;
            for (int i = D - 2; i >= 0; i--) begin
                if (!m[i+1].v && m[i].v) begin
                    m[i+1]  = m[i];
                    m[i].v  = 1'b0;
                end
            end
            if (!m[0].v && in_valid && !hz) begin
                m[0].v  = 1'b1;        m[0].pl = in_payload;  m[0].rd = in_rd;
                m[0].rw = in_regwrite; m[0].ld = in_is_load;
                m[0].s0 = in_src[4:0]; m[0].s1 = in_src[9:5];
            end
            for (int i = 0; i < D; i++) if (flush_mask[i]) m[i].v = 1'b0;
        end
    endtask

    task automatic cyc(input bit has_row, input vec_t r, input int idx);
        @(negedge clk);
        model_check();
        if (has_row) begin
            chk($sformatf("row%0d_ctl", idx), {in_ready, load_use_stall, stage_valid, fwd_sel, out_valid},
                {r.e_ir, r.e_st, r.e_sv, r.e_fwd, r.e_ov});
            if (r.e_ov) chk($sformatf("row%0d_out_rd", idx), out_rd, r.e_ord);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step();
        cyc(1'b0, nullv, 0);
    endtask

    task automatic drive(input bit iv, input logic [31:0] pl, input logic [4:0] rd, input bit rw,
                         input bit ld, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [2:0] fl, input bit ordy);
        in_valid = iv; in_payload = pl; in_rd = rd; in_regwrite = rw; in_is_load = ld;
        in_src = {s1, s0}; flush_mask = fl; out_ready = ordy;
    endtask

    function automatic vec_t mk(input bit rst, input bit iv, input int rd, input bit rw, input bit ld,
                                input int s0, input int s1, input bit ir, input bit ov, input int ord,
                                input int fwd, input bit st, input int sv);
        vec_t v;
        v.rst = rst; v.iv = iv; v.rd = 5'(rd); v.rw = rw; v.ld = ld; v.s0 = 5'(s0); v.s1 = 5'(s1);
        v.e_ir = ir; v.e_ov = ov; v.e_ord = 5'(ord); v.e_fwd = 4'(fwd); v.e_st = st; v.e_sv = 3'(sv);
        return v;
    endfunction

    initial begin
        nullv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //              rst iv rd rw ld s0 s1  ir ov ord fwd    st sv
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0,      0, 3'b000);
        tbl[1]  = mk(1, 1, 1, 1, 0, 0, 0,   1, 0, 0, 0,      0, 3'b000);
        tbl[2]  = mk(1, 1, 2, 1, 0, 0, 0,   1, 0, 0, 0,      0, 3'b001);
        tbl[3]  = mk(1, 1, 3, 1, 0, 0, 0,   1, 0, 0, 0,      0, 3'b011);
        tbl[4]  = mk(1, 1, 4, 1, 0, 0, 0,   1, 1, 1, 0,      0, 3'b111);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 2, 0,      0, 3'b111);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 3, 0,      0, 3'b110);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 4, 0,      0, 3'b100);
        tbl[8]  = mk(1, 1, 5, 1, 0, 0, 0,   1, 0, 0, 0,      0, 3'b000);
        tbl[9]  = mk(1, 1, 6, 1, 0, 5, 5,   1, 0, 0, 0,      0, 3'b001);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 4'b0101, 0, 3'b011);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 5, 0,      0, 3'b110);
        tbl[12] = mk(1, 1, 5, 1, 0, 0, 0,   1, 1, 6, 0,      0, 3'b100);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0,      0, 3'b001);
        tbl[14] = mk(1, 1, 6, 1, 0, 5, 5,   1, 0, 0, 0,      0, 3'b010);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 5, 4'b1010, 0, 3'b101);
        tbl[16] = mk(1, 1, 0, 1, 0, 0, 0,   1, 0, 0, 0,      0, 3'b010);
        tbl[17] = mk(1, 1, 8, 1, 0, 0, 0,   1, 1, 6, 0,      0, 3'b101);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0,      0, 3'b011);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0,      0, 3'b110);
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 8, 0,      0, 3'b100);
        tbl[21] = mk(1, 1, 7, 1, 1, 0, 0,   1, 0, 0, 0,      0, 3'b000);
        tbl[22] = mk(1, 1, 9, 1, 0, 7, 0,   0, 0, 0, 0,      1, 3'b001);
        tbl[23] = mk(1, 1, 9, 1, 0, 7, 0,   1, 0, 0, 0,      0, 3'b010);
        tbl[24] = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 7, 4'b0010, 0, 3'b101);
        tbl[25] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0,      0, 3'b010);
        tbl[26] = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 9, 0,      0, 3'b100);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 1);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            reset = tbl[i].rst;
            drive(tbl[i].iv, 32'h100 + i, tbl[i].rd, tbl[i].rw, tbl[i].ld, tbl[i].s0, tbl[i].s1, 3'b000, 1);
            cyc(1'b1, tbl[i], i);
        end
        chk("table_retire_count", retire_count, 12);
        chk("table_stall_count", stall_count, 1);

        // Back-pressure: fill with the sink blocked, hold five cycles, then drain in order.
        for (int n = 0; n < 3; n++) begin
            drive(1, 32'hA0 + n, 5'(10 + n), 1, 0, 0, 0, 3'b000, 0);
            step();
        end
        for (int n = 0; n < 5; n++) begin
            drive(1, 32'hD0, 5'd20, 1, 0, 0, 0, 3'b000, 0);
            #1;
            chk("bp_hold_payload", out_payload, 32'hA0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_stage_valid", stage_valid, 3'b111);
            chk("bp_no_retire", retire_count, 12);
            step();
        end
        for (int n = 0; n < 3; n++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 1);
            #1;
            chk("bp_drain_order", {out_valid, out_payload}, {1'b1, 32'hA0 + n});
            step();
        end
        chk("bp_retire_count", retire_count, 15);

        // Flush stages 0 and 1 of a full pipe while a new instruction is offered.
        for (int n = 0; n < 3; n++) begin
            drive(1, 32'hB0 + n, 5'(1 + n), 1, 0, 0, 0, 3'b000, 1);
            step();
        end
        drive(1, 32'hB3, 5'd4, 1, 0, 0, 0, 3'b011, 1);
        #1;
        chk("flush_in_ready", in_ready, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 1);
        #1;
        chk("flush_stage_valid", stage_valid, 3'b100);
        chk("flush_survivor", out_payload, 32'hB1);
        step();
        step();
        chk("flush_dropped", stage_valid, 3'b000);

        // Reset for one cycle in the middle of a full, stalled pipe.
        for (int n = 0; n < 3; n++) begin
            drive(1, 32'hC0 + n, 5'(1 + n), 1, 0, 0, 0, 3'b000, 0);
            step();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        #1;
        chk("rst_hold_in_ready", in_ready, 1);
        chk("rst_hold_out_valid", out_valid, 0);
        step();
        reset = 1'b1;
        #1;
        chk("rst_stage_valid", stage_valid, 3'b000);
        chk("rst_counters", {retire_count, stall_count}, 64'd0);
        chk("rst_in_ready", in_ready, 1);
        step();

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                  $urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
